// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared constants, state enum and die decode helpers for dice_roll_ctrl
//
// Purpose: die-select encodings, value width, controller state enum and the
//          sides/limit decode functions used by dice_roll_ctrl and dice_reduce.
// Ports:   none (package).
// Config:  DICE_ADVANTAGE_EN adds the ST_ROLL2 state.

package dice_pkg;

  localparam int VAL_W = 5;

  localparam logic [2:0] DIE_D4  = 3'd0;
  localparam logic [2:0] DIE_D6  = 3'd1;
  localparam logic [2:0] DIE_D8  = 3'd2;
  localparam logic [2:0] DIE_D10 = 3'd3;
  localparam logic [2:0] DIE_D12 = 3'd4;
  localparam logic [2:0] DIE_D20 = 3'd5;

`ifdef DICE_ADVANTAGE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_ROLL2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
`endif

  // Codes 6 and 7 fall through to d20.
  function automatic logic [VAL_W-1:0] die_sides(input logic [2:0] sel);
    case (sel)
      DIE_D4:  return 5'd4;
      DIE_D6:  return 5'd6;
      DIE_D8:  return 5'd8;
      DIE_D10: return 5'd10;
      DIE_D12: return 5'd12;
      default: return 5'd20;
    endcase
  endfunction

  // Largest multiple of the side count that fits in 1..31; samples above it
  // are rejected so every face is equally likely.
  function automatic logic [VAL_W-1:0] die_limit(input logic [2:0] sel);
    case (sel)
      DIE_D4:  return 5'd28;
      DIE_D6:  return 5'd30;
      DIE_D8:  return 5'd24;
      DIE_D10: return 5'd30;
      DIE_D12: return 5'd24;
      default: return 5'd20;
    endcase
  endfunction

endpackage

// File: rtl/dice_reduce.sv
// rtl/dice_reduce.sv - combinational rejection test and 1..sides reduction of a raw sample
//
// Purpose: accept = (1 <= rand_in <= limit); value = ((rand_in-1) mod sides) + 1.
// Ports:
//   rand_in  in  5  raw sample
//   sides    in  5  number of faces of the latched die
//   limit    in  5  acceptance ceiling for that die
//   accept   out 1  sample is usable
//   value    out 5  reduced face value (meaningful only when accept=1)

module dice_reduce
  import dice_pkg::*;
(
  input  logic [VAL_W-1:0] rand_in,
  input  logic [VAL_W-1:0] sides,
  input  logic [VAL_W-1:0] limit,
  output logic             accept,
  output logic [VAL_W-1:0] value
);

  logic [VAL_W-1:0] rem;

  assign accept = (rand_in != '0) && (rand_in <= limit);

  // Repeated conditional subtraction instead of a divider: the worst case is
  // d4 with a sample of 28 (27 = 6*4 + 3), so seven steps always suffice.
  always_comb begin
    rem = rand_in - 5'd1;
    for (int i = 0; i < 7; i++) begin
      if (rem >= sides) begin
        rem = rem - sides;
      end
    end
    value = rem + 5'd1;
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// rtl/dice_roll_ctrl.sv - fair die roller with animation value and valid/ack result handshake
//
// Purpose: on roll_req, latch the die type, animate roll_value with accepted
//          random samples for at least ROLL_CYCLES cycles, then hold the final
//          result with result_valid until result_ack.
// Parameters:
//   ROLL_CYCLES  minimum rolling-phase length, 1..255 (default 16)
// Ports:
//   clk           in  1  rising-edge clock
//   reset         in  1  synchronous active-high reset
//   rand_in       in  5  raw random sample
//   rand_valid    in  1  rand_in is fresh this cycle
//   roll_req      in  1  start a roll (IDLE only)
//   die_sel       in  3  die type, latched at roll_req
//   adv           in  1  roll twice, keep the higher (DICE_ADVANTAGE_EN only)
//   busy          out 1  roll in progress or result pending
//   roll_value    out 5  animation value while rolling, final result in DONE
//   result_valid  out 1  roll_value is final
//   result_ack    in  1  consumer takes the result
// Config: DICE_ADVANTAGE_EN enables adv, the second rolling phase and the first register.

module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int ROLL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] rand_in,
  input  logic             rand_valid,
  input  logic             roll_req,
  input  logic [2:0]       die_sel,
`ifdef DICE_ADVANTAGE_EN
  input  logic             adv,
`endif
  output logic             busy,
  output logic [VAL_W-1:0] roll_value,
  output logic             result_valid,
  input  logic             result_ack
);

  localparam logic [7:0] CNT_LOAD = 8'(ROLL_CYCLES);
`ifdef DICE_ADVANTAGE_EN
  // The transition into the second phase already spends one cycle, so the
  // reload is one less; this keeps the best case at 2*ROLL_CYCLES+1 edges.
  localparam logic [7:0] CNT_RELOAD = 8'(ROLL_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [VAL_W-1:0] sides_q, sides_d;
  logic [VAL_W-1:0] limit_q, limit_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             got_q, got_d;
  logic [VAL_W-1:0] value_q, value_d;
`ifdef DICE_ADVANTAGE_EN
  logic             adv_q, adv_d;
  logic [VAL_W-1:0] first_q, first_d;
`endif

  logic             accept;
  logic [VAL_W-1:0] red_value;
  logic             acc_now;
  logic             rolling;
  logic             phase_done;
  logic [VAL_W-1:0] phase_val;

  dice_reduce u_reduce (
    .rand_in (rand_in),
    .sides   (sides_q),
    .limit   (limit_q),
    .accept  (accept),
    .value   (red_value)
  );

`ifdef DICE_ADVANTAGE_EN
  assign rolling = (state_q == ST_ROLL) || (state_q == ST_ROLL2);
`else
  assign rolling = (state_q == ST_ROLL);
`endif

  assign acc_now    = rand_valid && accept;
  // A sample accepted in the closing cycle counts toward that phase.
  assign phase_val  = acc_now ? red_value : value_q;
  assign phase_done = (cnt_q == 8'd0) && (got_q || acc_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sides_q <= 5'd20;
      limit_q <= 5'd20;
      cnt_q   <= 8'd0;
      got_q   <= 1'b0;
      value_q <= '0;
`ifdef DICE_ADVANTAGE_EN
      adv_q   <= 1'b0;
      first_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sides_q <= sides_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      got_q   <= got_d;
      value_q <= value_d;
`ifdef DICE_ADVANTAGE_EN
      adv_q   <= adv_d;
      first_q <= first_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sides_d = sides_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    got_d   = got_q;
    value_d = value_q;
`ifdef DICE_ADVANTAGE_EN
    adv_d   = adv_q;
    first_d = first_q;
`endif

    // Common rolling behaviour: saturating countdown and animation update.
    if (rolling) begin
      cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
      if (acc_now) begin
        value_d = red_value;
        got_d   = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (roll_req) begin
          sides_d = die_sides(die_sel);
          limit_d = die_limit(die_sel);
          cnt_d   = CNT_LOAD;
          got_d   = 1'b0;
`ifdef DICE_ADVANTAGE_EN
          adv_d   = adv;
`endif
          state_d = ST_ROLL;
        end
      end
      ST_ROLL: begin
        if (phase_done) begin
`ifdef DICE_ADVANTAGE_EN
          if (adv_q) begin
            first_d = phase_val;
            cnt_d   = CNT_RELOAD;
            got_d   = 1'b0;
            state_d = ST_ROLL2;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef DICE_ADVANTAGE_EN
      ST_ROLL2: begin
        if (phase_done) begin
          value_d = (first_q > phase_val) ? first_q : phase_val;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (result_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign roll_value   = value_q;

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Consumer of the 5-bit pseudo-random stream produced by the on-chip LFSR. The block turns a roll request plus a die selection into one fair, held die result. Fairness comes from rejection sampling, so there is no modulo bias. While rolling, it drives a changing animation value; the final result is offered to the display/host logic through a valid/ack handshake.

## Interface
- `ROLL_CYCLES`, default 16: minimum number of cycles spent in each rolling phase (animation length); legal range 1–255.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `rand_in`  in  5  raw random sample, values 1–31; 0 is legal and is always rejected.
- `rand_valid`  in  1  `rand_in` is a fresh sample this cycle.
- `roll_req`  in  1  request a roll; sampled only in IDLE.
- `die_sel`  in  3  die type: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20; 6 and 7 are treated as d20.
- `adv`  in  1  advantage request, sampled with `roll_req`. Present only with `DICE_ADVANTAGE_EN`.
- `busy`  out  1  a roll is in progress (ROLL, ROLL2 or DONE).
- `roll_value`  out  5  latest accepted value while rolling; the final result in DONE.
- `result_valid`  out  1  `roll_value` is final.
- `result_ack`  in  1  consumer accepts the result.

## Operation
- **States:** IDLE, ROLL, ROLL2, DONE.
- **IDLE:**
  - `roll_req`=1 latches `die_sel` (decoded to `sides`) and `adv`, loads the phase counter with `ROLL_CYCLES`, clears the `got_sample` flag, and moves to ROLL.
  - `die_sel` changes after latching have no effect on the roll in progress.
- **Acceptance rule** (each cycle in ROLL/ROLL2 with `rand_valid`=1):
  - A sample `r` is accepted iff 1 ≤ `r` ≤ LIMIT, where LIMIT is the largest multiple of `sides` that is ≤ 31: d4=28, d6=30, d8=24, d10=30, d12=24, d20=20.
  - An accepted sample updates `roll_value` to ((`r`−1) mod `sides`)+1, which is always in 1..`sides`, and sets `got_sample`.
  - A rejected sample leaves `roll_value` unchanged.
- **Phase counter:** decrements each cycle in ROLL/ROLL2 (independent of `rand_valid`) and saturates at 0.
- **Phase ends** in the cycle where counter==0 and `got_sample`=1, counting an acceptance in that same cycle:
  - In ROLL with `adv`=0: go to DONE.
  - In ROLL with `adv`=1: store `roll_value` as `first`, reload the counter, clear `got_sample`, and go to ROLL2.
  - In ROLL2: the final result is max(`first`, that phase's value); go to DONE.
- **Stalls:** if the counter reaches 0 with no accepted sample yet, the block stays in ROLL/ROLL2 until one is accepted. There is no timeout.
- **DONE:**
  - `result_valid`=1 and `roll_value` held stable.
  - `result_ack`=1 moves to IDLE.
  - `roll_req` is ignored in DONE.
- **Reset** (any state, including mid-roll): go to IDLE. `busy`=0, `result_valid`=0, `roll_value`=0, counter=0, `first`=0, latched `sides`=20, `adv`=0.

## Timing
- `busy` is registered: it rises the cycle after `roll_req` is sampled in IDLE.
- Best-case latency with every sample accepted:
  - `roll_req` sampled at edge t → `result_valid`=1 after edge t+ROLL_CYCLES+1.
  - With advantage: after edge t+2·ROLL_CYCLES+1.
- `roll_value` updates on the edge after an accepted sample.
- `result_valid` and `result_ack` both high at edge e: IDLE after e, `result_valid`=0 after e.
- A `roll_req` at edge e+1 starts the next roll (minimum 1 IDLE cycle between rolls).
- `result_ack` outside DONE is ignored.

## Configuration
- `DICE_ADVANTAGE_EN`:
  - Defined: the `adv` port, the ROLL2 state and the `first` register exist, and behaviour is as described above.
  - Undefined: no `adv` port, no ROLL2 state, no `first` register; every roll is single-phase.

## Structure
- Package `dice_pkg`:
  - die-select encoding constants (`DIE_D4`..`DIE_D20`);
  - state enum;
  - functions `die_sides(sel)` and `die_limit(sel)`;
  - 5-bit value width constant.
- Sub-module `dice_reduce`, combinational: (`rand_in`, `sides`, `limit`) → (`accept`, `value`). The mod is done by bounded conditional subtraction, at most 7 steps for d4.

## Test plan
- d6, `ROLL_CYCLES`=4, `rand_in`=8 valid every cycle, `roll_req` pulse → `busy` next cycle, `result_valid` after 5 edges, `roll_value`=2; hold until `result_ack`.
- d20, `rand_in`=25 (rejected) for 10 cycles then 13 → stays in ROLL past the counter expiry, result 13 one cycle after acceptance.
- d4, `rand_in` sequence 29, 31, 0, 5 → first three rejected, result 1; value never exceeds 4 over 1000 random samples for every die.
- `DICE_ADVANTAGE_EN`, d20, `adv`=1, phase 1 samples end on 17, phase 2 end on 3 → result 17; swap order → still 17.
- Reset asserted mid-ROLL → next cycle `busy`=0, `result_valid`=0, `roll_value`=0, state IDLE; a new roll then completes normally.
- `result_ack` in the same cycle as `result_valid` rises, then `roll_req` immediately, with `die_sel` changing mid-roll → back-to-back rolls, the second using the die latched at its request.
